captura_jogada: RTL

//   Input-capture stage directly upstream of the main game FSM (jogo_principal / registra_tiro).

---
 rtl/captura_jogada_if.sv | 29 ++
 rtl/captura_jogada.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/captura_jogada_if.sv
// -----------------------------------------------------------------------------
// captura_jogada_if
//   Handshake between the input-capture stage (captura_jogada) and the game FSM.
//   master : the capture stage, which presents the head action.
//   slave  : the game FSM, which consumes it.
// Signals
//   jogada_valida  master->slave  an action is pending at the head
//   jogada         master->slave  head action code (LARGURA bits)
//   consome        slave->master  pop the head this cycle (only meaningful while valid)
// -----------------------------------------------------------------------------
interface captura_jogada_if #(
    parameter int LARGURA = 6
);
    logic               jogada_valida;
    logic [LARGURA-1:0] jogada;
    logic               consome;

    modport master (
        output jogada_valida,
        output jogada,
        input  consome
    );

    modport slave (
        input  jogada_valida,
        input  jogada,
        output consome
    );
endinterface

// File: rtl/captura_jogada.sv
// -----------------------------------------------------------------------------
// captura_jogada
//   Synchronises and debounces the raw player switches, accepts one action per
//   press and buffers it until the game FSM consumes it via fila.consome.
//   A held key is captured once; it must be released before another capture.
// Build option
//   JOGADA_FILA2_EN  defined   -> 2-entry buffer (head + follower)
//                    undefined -> single-entry buffer
// Ports
//   clock         rising-edge system clock
//   reset         asynchronous, active-high; clears all state
//   habilita      game running; no new press accepted while low
//   chaves        raw asynchronous switches (action code)
//   fila          master side of captura_jogada_if (jogada_valida, jogada, consome)
//   db_descartes  saturating count of presses dropped on a full buffer
//   db_estado     FSM state code for debug displays
// -----------------------------------------------------------------------------
module captura_jogada #(
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int LARGURA         = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                habilita,
    input  logic [LARGURA-1:0]  chaves,
    captura_jogada_if.master    fila,
    output logic [3:0]          db_descartes,
    output logic [1:0]          db_estado
);
    localparam int                CONT_W   = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CONT_W-1:0] CONT_MAX = CONT_W'(DEBOUNCE_CICLOS - 1);
    localparam logic [LARGURA-1:0] ZERO    = {LARGURA{1'b0}};

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        ESTABILIZA = 2'd1,
        REGISTRA   = 2'd2,
        SOLTA      = 2'd3
    } estado_t;

    logic [LARGURA-1:0] sinc1_r, sinc_r;
    estado_t            estado_r, estado_s;
    logic [LARGURA-1:0] amostra_r, amostra_s;
    logic [CONT_W-1:0]  cont_r, cont_s;
    logic [LARGURA-1:0] head_r, head_s;
    logic               head_valid_r, head_valid_s;
    logic [3:0]         descartes_r, descartes_s;
    logic               pop_s, grava_s, descarta_s;
`ifdef JOGADA_FILA2_EN
    logic [LARGURA-1:0] fol_r, fol_s;
    logic               fol_valid_r, fol_valid_s;
`endif

    // Debounce FSM: next state, captured sample and stability counter.
    always_comb begin
        estado_s  = estado_r;
        amostra_s = amostra_r;
        cont_s    = cont_r;
        case (estado_r)
            OCIOSO: begin
                if (habilita && (sinc_r != ZERO)) begin
                    amostra_s = sinc_r;
                    cont_s    = {CONT_W{1'b0}};
                    estado_s  = ESTABILIZA;
                end else begin
                    estado_s  = OCIOSO;
                end
            end
            ESTABILIZA: begin
                // Abort has priority over completion: the last compare must also match.
                if (!habilita || (sinc_r != amostra_r)) begin
                    estado_s = OCIOSO;
                end else if (cont_r == CONT_MAX) begin
                    estado_s = REGISTRA;
                end else begin
                    cont_s   = cont_r + {{(CONT_W-1){1'b0}}, 1'b1};
                end
            end
            REGISTRA: begin
                estado_s = SOLTA;
            end
            SOLTA: begin
                if (sinc_r == ZERO) begin
                    estado_s = OCIOSO;
                end else begin
                    estado_s = SOLTA;
                end
            end
            default: begin
                estado_s = OCIOSO;
            end
        endcase
    end

    // Action buffer: the pop is applied before the write so a same-edge write always fits.
    always_comb begin
        pop_s        = head_valid_r & fila.consome;
        grava_s      = (estado_r == REGISTRA);
        descarta_s   = 1'b0;
        head_s       = head_r;
        head_valid_s = head_valid_r;
`ifdef JOGADA_FILA2_EN
        fol_s        = fol_r;
        fol_valid_s  = fol_valid_r;
        if (pop_s) begin
            head_s       = fol_valid_r ? fol_r : ZERO;
            head_valid_s = fol_valid_r;
            fol_s        = ZERO;
            fol_valid_s  = 1'b0;
        end else begin
            head_valid_s = head_valid_r;
        end
        if (grava_s) begin
            if (!head_valid_s) begin
                head_s       = amostra_r;
                head_valid_s = 1'b1;
            end else if (!fol_valid_s) begin
                fol_s        = amostra_r;
                fol_valid_s  = 1'b1;
            end else begin
                descarta_s   = 1'b1;
            end
        end else begin
            descarta_s = 1'b0;
        end
`else
        if (pop_s) begin
            head_s       = ZERO;
            head_valid_s = 1'b0;
        end else begin
            head_valid_s = head_valid_r;
        end
        if (grava_s) begin
            if (!head_valid_s) begin
                head_s       = amostra_r;
                head_valid_s = 1'b1;
            end else begin
                descarta_s   = 1'b1;
            end
        end else begin
            descarta_s = 1'b0;
        end
`endif
        if (descarta_s && (descartes_r != 4'hF)) begin
            descartes_s = descartes_r + 4'd1;
        end else begin
            descartes_s = descartes_r;
        end
    end

    // State, synchroniser and buffer registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinc1_r      <= ZERO;
            sinc_r       <= ZERO;
            estado_r     <= OCIOSO;
            amostra_r    <= ZERO;
            cont_r       <= {CONT_W{1'b0}};
            head_r       <= ZERO;
            head_valid_r <= 1'b0;
            descartes_r  <= 4'd0;
`ifdef JOGADA_FILA2_EN
            fol_r        <= ZERO;
            fol_valid_r  <= 1'b0;
`endif
        end else begin
            sinc1_r      <= chaves;
            sinc_r       <= sinc1_r;
            estado_r     <= estado_s;
            amostra_r    <= amostra_s;
            cont_r       <= cont_s;
            head_r       <= head_s;
            head_valid_r <= head_valid_s;
            descartes_r  <= descartes_s;
`ifdef JOGADA_FILA2_EN
            fol_r        <= fol_s;
            fol_valid_r  <= fol_valid_s;
`endif
        end
    end

    assign fila.jogada_valida = head_valid_r;
    assign fila.jogada        = head_r;
    assign db_descartes       = descartes_r;
    assign db_estado          = estado_r;
endmodule
